inp: RTL

Block-input unit for the MIX system; the receive-side counterpart of the line-printer output unit. It receives ASCII characters over a serial UART line and converts each one to a 6-bit MIX character code. It packs five codes per 30-bit word and hands 14 words per block (one 70-character line) to the CPU through a request/acknowledge memory-write handshake, starting at a CPU-supplied address. It sits beside the CPU as an I/O unit; the CPU issues `start` and later resumes on `stop`.

---
 rtl/inp.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/inp.sv
// Block-input unit for the MIX system.
// Receives ASCII over a UART line, maps each byte to a 6-bit MIX code, packs five
// codes per 30-bit word and hands 14 words (one 70-character line) per block to the
// CPU through a request/ack memory-write handshake.
//
// Ports (inp):
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   rx         in   UART serial input, idle high
//   start      in   one-cycle command: read one block at addressin
//   addressin  in   [11:0] block base address, sampled with start
//   ack        in   CPU has written out to addressout
//   out        out  [29:0] packed word, first character in [29:24]
//   addressout out  [11:0] memory address for out
//   request    out  out/addressout valid, write wanted
//   stop       out  one-cycle pulse at block end
//   busy       out  a block is in progress
//   overrun    out  sticky: a completed word was lost
//
// Ports (UartRX): clk, reset, rx in; out[7:0] received byte; ready one-cycle strobe.

module UartRX #(
    parameter int unsigned ClksPerBit = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] out,
    output logic       ready
);
    localparam int unsigned CntW = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2 - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            ready_q, ready_d;
    logic [1:0]      sync_q;
    logic            rx_s;

    assign rx_s  = sync_q[1];
    assign out   = sh_q;
    assign ready = ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ready_q <= 1'b0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ready_q <= ready_d;
            sync_q  <= {sync_q[0], rx};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        ready_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                // Re-check at mid start bit to reject glitches.
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    ready_d = rx_s;
                end
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

module inp (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        start,
    input  logic [11:0] addressin,
    input  logic        ack,
    output logic [29:0] out,
    output logic [11:0] addressout,
    output logic        request,
    output logic        stop,
    output logic        busy,
    output logic        overrun
);
    localparam logic [7:0] Lf      = 8'h0a;
    localparam logic [7:0] Cr      = 8'h0d;
    localparam logic [6:0] LineLen = 7'd70;
    localparam logic [3:0] BlkLen  = 4'd14;

    typedef enum logic [1:0] {StIdle, StRecv, StPad} state_e;

    state_e      state_q, state_d;
    logic [11:0] addr_q, addr_d, pend_addr_q, pend_addr_d;
    logic [3:0]  wc_q, wc_d;
    logic [2:0]  cc_q, cc_d;
    logic [6:0]  lc_q, lc_d;   // characters placed in the current block
    logic [23:0] asm_q, asm_d;
    logic [29:0] out_q, out_d;
    logic        req_q, req_d, stop_q, stop_d, ovr_q, ovr_d;
    logic        skip_q, skip_d, pend_q, pend_d;

    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic        have_code, drop, acked, blk_end;
    logic [5:0]  code;

    UartRX #(.ClksPerBit(8)) u_rx (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .out   (rx_byte),
        .ready (rx_ready)
    );

    function automatic logic [5:0] map_char(input logic [7:0] raw);
        logic [7:0] b;
        logic [5:0] c;
        b = (raw >= 8'h61 && raw <= 8'h7a) ? raw - 8'h20 : raw;
        c = 6'd0;
        if (b >= 8'h41 && b <= 8'h49)      c = 6'(b - 8'h40);  // A-I -> 1-9
        else if (b >= 8'h4a && b <= 8'h52) c = 6'(b - 8'h3f);  // J-R -> 11-19
        else if (b >= 8'h53 && b <= 8'h5a) c = 6'(b - 8'h3d);  // S-Z -> 22-29
        else if (b >= 8'h30 && b <= 8'h39) c = 6'(b - 8'h12);  // 0-9 -> 30-39
        else begin
            case (b)
                8'h07:   c = 6'd21;
                8'h2e:   c = 6'd40;
                8'h2c:   c = 6'd41;
                8'h28:   c = 6'd42;
                8'h29:   c = 6'd43;
                8'h2b:   c = 6'd44;
                8'h2d:   c = 6'd45;
                8'h2a:   c = 6'd46;
                8'h2f:   c = 6'd47;
                8'h3d:   c = 6'd48;
                8'h24:   c = 6'd49;
                8'h3c:   c = 6'd50;
                8'h3e:   c = 6'd51;
                8'h40:   c = 6'd52;
                8'h3b:   c = 6'd53;
                8'h3a:   c = 6'd54;
                8'h27:   c = 6'd55;
                default: c = 6'd0;
            endcase
        end
        return c;
    endfunction

    assign out        = out_q;
    assign addressout = addr_q;
    assign request    = req_q;
    assign stop       = stop_q;
    assign busy       = (state_q != StIdle);
    assign overrun    = ovr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            pend_addr_q <= '0;
            wc_q        <= '0;
            cc_q        <= '0;
            lc_q        <= '0;
            asm_q       <= '0;
            out_q       <= '0;
            req_q       <= 1'b0;
            stop_q      <= 1'b0;
            ovr_q       <= 1'b0;
            skip_q      <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pend_addr_q <= pend_addr_d;
            wc_q        <= wc_d;
            cc_q        <= cc_d;
            lc_q        <= lc_d;
            asm_q       <= asm_d;
            out_q       <= out_d;
            req_q       <= req_d;
            stop_q      <= stop_d;
            ovr_q       <= ovr_d;
            skip_q      <= skip_d;
            pend_q      <= pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pend_addr_d = pend_addr_q;
        cc_d        = cc_q;
        lc_d        = lc_q;
        asm_d       = asm_q;
        out_d       = out_q;
        req_d       = req_q;
        stop_d      = 1'b0;
        ovr_d       = ovr_q;
        skip_d      = skip_q;
        pend_d      = pend_q;
        have_code   = 1'b0;
        code        = 6'd0;
        drop        = 1'b0;
        acked       = 1'b0;

        // Received byte: skipline has priority in every state.
        if (rx_ready) begin
            if (skip_q) begin
                if (rx_byte == Lf) skip_d = 1'b0;
            end else if (state_q == StRecv && lc_q < LineLen) begin
                if (rx_byte == Lf) begin
                    state_d = StPad;
                end else if (rx_byte != Cr) begin
                    have_code = 1'b1;
                    code      = map_char(rx_byte);
                    if (lc_q == LineLen - 7'd1) skip_d = 1'b1;
                end
            end
        end

        // Padding stalls rather than dropping a word.
        if (state_q == StPad && lc_q < LineLen && !(cc_q == 3'd4 && req_q)) begin
            have_code = 1'b1;
        end

        if (have_code) begin
            lc_d = lc_q + 7'd1;
            if (cc_q == 3'd4) begin
                cc_d = '0;
                if (req_q) begin
                    drop  = 1'b1;
                    ovr_d = 1'b1;
                end else begin
                    out_d = {asm_q, code};
                    req_d = 1'b1;
                end
            end else begin
                asm_d = {asm_q[17:0], code};
                cc_d  = cc_q + 3'd1;
            end
        end

        if (ack && req_q) begin
            acked  = 1'b1;
            req_d  = 1'b0;
            addr_d = addr_q + 12'd1;
        end

        wc_d    = wc_q + {3'b000, drop} + {3'b000, acked};
        blk_end = (state_q != StIdle) && (wc_d >= BlkLen);

        if (blk_end) begin
            stop_d  = 1'b1;
            state_d = StIdle;
            if (pend_q && !start) begin
                state_d = StRecv;
                addr_d  = pend_addr_q;
                wc_d    = '0;
                cc_d    = '0;
                lc_d    = '0;
                pend_d  = 1'b0;
            end
        end

        if (start) begin
            if (state_q == StIdle || blk_end) begin
                state_d = StRecv;
                addr_d  = addressin;
                wc_d    = '0;
                cc_d    = '0;
                lc_d    = '0;
                ovr_d   = 1'b0;
                pend_d  = 1'b0;
            end else begin
                pend_d      = 1'b1;
                pend_addr_d = addressin;
            end
        end
    end
endmodule
